// File: rtl/arm_lp_pkg.sv
// Shared constants and types for the instruction fetch cache.
//   PC_STRIDE_SHIFT : number of low PC bits dropped (8-byte fetch stride)
//   DEF_INSTR_W     : default instruction width
//   ic_state_e      : fetch cache controller states
package arm_lp_pkg;

    localparam int unsigned PC_STRIDE_SHIFT = 3;
    localparam int unsigned DEF_INSTR_W     = 32;

    typedef enum logic [0:0] {
        IC_IDLE = 1'b0,
        IC_FILL = 1'b1
    } ic_state_e;

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// Combinational lookup (rd_hit/rd_data), synchronous fill write, flush-all.
// Ports:
//   clock, reset_n         : clock, async active-low reset (clears valid bits)
//   flush                  : clear every valid bit on this edge
//   rd_index, rd_tag       : lookup address fields
//   rd_hit, rd_data        : lookup result
//   wr_en, wr_index,
//   wr_tag, wr_data        : install one line
module icache_line_array
    import arm_lp_pkg::*;
#(
    parameter int unsigned LINES   = 16,
    parameter int unsigned TAG_W   = 25,
    parameter int unsigned INSTR_W = DEF_INSTR_W,
    localparam int unsigned IDX_W  = $clog2(LINES)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               flush,
    input  logic [IDX_W-1:0]   rd_index,
    input  logic [TAG_W-1:0]   rd_tag,
    output logic               rd_hit,
    output logic [INSTR_W-1:0] rd_data,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [INSTR_W-1:0] wr_data
);

    logic [LINES-1:0]   valid;
    logic [TAG_W-1:0]   tags  [LINES];
    logic [INSTR_W-1:0] words [LINES];

    // Valid bits: flush wins over a same-edge install.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // Tag/data payload needs no reset; valid guards it.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            tags[wr_index]  <= wr_tag;
            words[wr_index] <= wr_data;
        end
    end

    assign rd_hit  = valid[rd_index] && (tags[rd_index] == rd_tag);
    assign rd_data = words[rd_index];

endmodule

// File: rtl/instr_fetch_cache.sv
// Direct-mapped instruction cache between the fetch stage and instruction memory.
// Hits answer one cycle after acceptance; misses fill over a memReq/memAck handshake.
// Ports:
//   clock, reset_n            : clock, async active-low reset
//   fetchValid, fetchAddr     : fetch request (fetchAddr[2:0] ignored)
//   fetchReady                : request accepted this cycle when high (decoded from state)
//   instrValid, instruction   : one-cycle registered response
//   flush                     : invalidate all lines
//   memReq, memAddr           : fill request (registered, held until memAck)
//   memAck, memData           : fill response
//   hitCount, missCount       : saturating counters, only with ICACHE_STATS_EN
// Optional feature macro: ICACHE_STATS_EN
module instr_fetch_cache
    import arm_lp_pkg::*;
#(
    parameter int unsigned LINES   = 16,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INSTR_W = DEF_INSTR_W
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               fetchValid,
    input  logic [ADDR_W-1:0]  fetchAddr,
    output logic               fetchReady,
    output logic               instrValid,
    output logic [INSTR_W-1:0] instruction,
    input  logic               flush,
    output logic               memReq,
    output logic [ADDR_W-1:0]  memAddr,
    input  logic               memAck,
    input  logic [INSTR_W-1:0] memData
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0]        hitCount,
    output logic [15:0]        missCount
`endif
);

    localparam int unsigned IDX_W  = $clog2(LINES);
    localparam int unsigned IDX_LO = PC_STRIDE_SHIFT;
    localparam int unsigned TAG_LO = PC_STRIDE_SHIFT + IDX_W;
    localparam int unsigned TAG_W  = ADDR_W - TAG_LO;

    ic_state_e          state;
    logic               flush_seen;
    logic               hit;
    logic [INSTR_W-1:0] line_data;
    logic               accept;
    logic               acc_hit;
    logic               acc_miss;
    logic               fill_done;
    logic               fill_wr;
    logic               unused_low;

    // Stride bits never select anything.
    assign unused_low = ^fetchAddr[PC_STRIDE_SHIFT-1:0];

    assign fetchReady = (state == IC_IDLE);
    assign accept     = fetchValid && fetchReady;
    // A same-cycle flush invalidates before lookup, so it forces a miss.
    assign acc_hit    = accept && hit && !flush;
    assign acc_miss   = accept && !(hit && !flush);
    assign fill_done  = (state == IC_FILL) && memAck;
    // A flush anywhere in the fill window (including the ack edge) blocks install.
    assign fill_wr    = fill_done && !flush_seen && !flush;

    icache_line_array #(
        .LINES   (LINES),
        .TAG_W   (TAG_W),
        .INSTR_W (INSTR_W)
    ) u_lines (
        .clock    (clock),
        .reset_n  (reset_n),
        .flush    (flush),
        .rd_index (fetchAddr[TAG_LO-1:IDX_LO]),
        .rd_tag   (fetchAddr[ADDR_W-1:TAG_LO]),
        .rd_hit   (hit),
        .rd_data  (line_data),
        .wr_en    (fill_wr),
        .wr_index (memAddr[TAG_LO-1:IDX_LO]),
        .wr_tag   (memAddr[ADDR_W-1:TAG_LO]),
        .wr_data  (memData)
    );

    // Controller FSM with registered response and fill request.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IC_IDLE;
            memReq      <= 1'b0;
            memAddr     <= '0;
            instrValid  <= 1'b0;
            instruction <= '0;
            flush_seen  <= 1'b0;
        end else begin
            instrValid <= 1'b0;
            case (state)
                IC_IDLE: begin
                    if (acc_hit) begin
                        instruction <= line_data;
                        instrValid  <= 1'b1;
                    end else if (acc_miss) begin
                        memAddr    <= {fetchAddr[ADDR_W-1:IDX_LO], IDX_LO'(0)};
                        memReq     <= 1'b1;
                        flush_seen <= 1'b0;
                        state      <= IC_FILL;
                    end
                end
                IC_FILL: begin
                    if (flush) begin
                        flush_seen <= 1'b1;
                    end
                    if (memAck) begin
                        instruction <= memData;
                        instrValid  <= 1'b1;
                        memReq      <= 1'b0;
                        state       <= IC_IDLE;
                    end
                end
                default: begin
                    state <= IC_IDLE;
                end
            endcase
        end
    end

`ifdef ICACHE_STATS_EN
    // Saturating hit/miss counters; survive flush, cleared only by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hitCount  <= '0;
            missCount <= '0;
        end else begin
            if (acc_hit && (hitCount != 16'hFFFF)) begin
                hitCount <= hitCount + 16'd1;
            end
            if (acc_miss && (missCount != 16'hFFFF)) begin
                missCount <= missCount + 16'd1;
            end
        end
    end
`endif

endmodule
